// File: rtl/uart_rx_fifo.sv
// UART receiver with start-glitch rejection, optional parity, framing/break handling
// and a small receive FIFO with overrun detection.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          Rst_tx,
    input  logic                          Rs232,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int         PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_LAST = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic       ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    logic          syncMeta_q;
    logic          syncOut_q;
    logic          rx_s;
    logic [1:0]    settleCnt_q;
    logic          lineHigh_q;
    logic          lineHigh_d;

    state_t        state_q, state_d;
    logic [7:0]    baudCnt_q, baudCnt_d;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parityFail_q, parityFail_d;
    logic          push_q, push_d;
    logic [7:0]    pushData_q, pushData_d;
    logic          frameErr_q, frameErr_d;
    logic          parityErr_q, parityErr_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic [7:0]    lastHead_q;
    logic          pop;
    logic          full;
    logic          accept;

    assign rx_s = syncOut_q;

    // A start edge only counts once the synchronizer has settled after reset and
    // the line was seen high, so a line held low across reset is never a start.
    assign lineHigh_d = (settleCnt_q == 2'd2) && rx_s;

    always_ff @(posedge clk) begin
        if (Rst_tx) begin
            syncMeta_q  <= 1'b1;
            syncOut_q   <= 1'b1;
            settleCnt_q <= 2'd0;
            lineHigh_q  <= 1'b0;
        end else begin
            syncMeta_q  <= Rs232;
            syncOut_q   <= syncMeta_q;
            lineHigh_q  <= lineHigh_d;
            if (settleCnt_q != 2'd2) begin
                settleCnt_q <= settleCnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Rst_tx) begin
            state_q      <= IDLE;
            baudCnt_q    <= 8'd0;
            bitCnt_q     <= 3'd0;
            shift_q      <= 8'd0;
            parityFail_q <= 1'b0;
            push_q       <= 1'b0;
            pushData_q   <= 8'd0;
            frameErr_q   <= 1'b0;
            parityErr_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            baudCnt_q    <= baudCnt_d;
            bitCnt_q     <= bitCnt_d;
            shift_q      <= shift_d;
            parityFail_q <= parityFail_d;
            push_q       <= push_d;
            pushData_q   <= pushData_d;
            frameErr_q   <= frameErr_d;
            parityErr_q  <= parityErr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        baudCnt_d    = baudCnt_q + 8'd1;
        bitCnt_d     = bitCnt_q;
        shift_d      = shift_q;
        parityFail_d = parityFail_q;
        push_d       = 1'b0;
        pushData_d   = pushData_q;
        frameErr_d   = 1'b0;
        parityErr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                baudCnt_d = 8'd0;
                if (lineHigh_q && !rx_s) begin
                    state_d      = START;
                    parityFail_d = 1'b0;
                end
            end
            START: begin
                if (baudCnt_q == HALF_LAST) begin
                    baudCnt_d = 8'd0;
                    bitCnt_d  = 3'd0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baudCnt_q == BIT_LAST) begin
                    baudCnt_d = 8'd0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    if (bitCnt_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (baudCnt_q == BIT_LAST) begin
                    baudCnt_d = 8'd0;
                    state_d   = STOP;
                    if (rx_s != ((^shift_q) ^ ODD_BIT)) begin
                        parityFail_d = 1'b1;
                    end
                end
            end
            STOP: begin
                if (baudCnt_q == BIT_LAST) begin
                    baudCnt_d = 8'd0;
                    if (rx_s) begin
                        state_d = IDLE;
                        if (parityFail_q) begin
                            parityErr_d = 1'b1;
                        end else begin
                            push_d     = 1'b1;
                            pushData_d = shift_q;
                        end
                    end else begin
                        frameErr_d = 1'b1;
                        state_d    = BREAK;
                    end
                end
            end
            BREAK: begin
                baudCnt_d = 8'd0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop    = rx_valid && rx_ready;
    assign full   = (count_q == CW'(FIFO_DEPTH));
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign accept = push_q && (!full || pop);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wrPtr_q] <= pushData_q;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst_tx) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            lastHead_q <= 8'd0;
        end else begin
            if (accept) begin
                wrPtr_q <= nextPtr(wrPtr_q);
            end
            if (pop) begin
                rdPtr_q    <= nextPtr(rdPtr_q);
                lastHead_q <= mem_q[rdPtr_q];
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rx_valid   = (count_q != '0);
    assign rx_data    = rx_valid ? mem_q[rdPtr_q] : lastHead_q;
    assign fifo_count = count_q;
    assign parity_err = parityErr_q;
    assign frame_err  = frameErr_q;
    assign overrun    = push_q && full && !pop;

endmodule
